// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared widths, limits and kernel select type for the Sobel edge filter
package sobel_pkg;

    localparam int DATA_W  = 12;
    localparam int SUM_W   = DATA_W + 4;
    localparam int PIX_MAX = (1 << DATA_W) - 1;

    typedef enum logic {
        KER_GX = 1'b0,
        KER_GY = 1'b1
    } kernelSelT;

endpackage

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - single-port read-before-write line buffer, one image line deep
module sobel_line_buffer #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 1280,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Store the incoming pixel; the read port still returns the previous line's pixel this beat
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wrData;
        end
    end

    assign rdData = mem[addr];

endmodule

// File: rtl/sobel_edge_filter.sv
// rtl/sobel_edge_filter.sv - 3x3 Sobel edge filter on a raster pixel stream; SOBEL_MAG_EN selects sat(|Gx|+|Gy|) output
module sobel_edge_filter
    import sobel_pkg::*;
#(
    parameter int DATA_W = sobel_pkg::DATA_W,
    parameter int IMG_W  = 1280,
    parameter int CNT_W  = 11
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSOF,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    input  logic              iSel,
    output logic [DATA_W-1:0] oDATA,
    output logic              oDVAL
);

    localparam int SW = DATA_W + 4;
    localparam int AW = $clog2(IMG_W);
    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] TWO    = CNT_W'(2);

    // Position and frame state
    logic [CNT_W-1:0]  xCnt;
    logic [CNT_W-1:0]  yCnt;
    logic [CNT_W-1:0]  effX;
    logic [CNT_W-1:0]  effY;
    kernelSelT         kerSel;

    // Line buffer taps and 3x3 window, win[row][col], row 0 = top, col 0 = left
    logic [DATA_W-1:0] tap1;
    logic [DATA_W-1:0] tap2;
    logic [DATA_W-1:0] win [3][3];

    // Pipeline valid and border flags
    logic              v0;
    logic              b0;
    logic              v1;
    logic              b1;

    logic signed [SW-1:0] gx;
    logic signed [SW-1:0] gy;
    logic [SW:0]          mag;
    logic [DATA_W-1:0]    satPix;

    function automatic logic signed [SW-1:0] ext(input logic [DATA_W-1:0] p);
        return $signed(SW'(p));
    endfunction

    function automatic logic [SW-1:0] absVal(input logic signed [SW-1:0] s);
        return s[SW-1] ? SW'(-s) : SW'(s);
    endfunction

    // A start-of-frame beat is pixel (0,0) regardless of where the counters were
    always_comb begin
        effX = iSOF ? '0 : xCnt;
        effY = iSOF ? '0 : yCnt;
    end

    sobel_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .ADDR_W (AW)
    ) lb1 (
        .clk    (iCLK),
        .we     (iDVAL),
        .addr   (effX[AW-1:0]),
        .wrData (iDATA),
        .rdData (tap1)
    );

    sobel_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .ADDR_W (AW)
    ) lb2 (
        .clk    (iCLK),
        .we     (iDVAL),
        .addr   (effX[AW-1:0]),
        .wrData (tap1),
        .rdData (tap2)
    );

    // Column/row counters advance per beat; kernel select is captured only on start of frame
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            xCnt   <= '0;
            yCnt   <= '0;
            kerSel <= KER_GX;
        end else if (iDVAL) begin
            if (iSOF) begin
                kerSel <= kernelSelT'(iSel);
            end
            if (effX == X_LAST) begin
                xCnt <= '0;
                yCnt <= effY + CNT_W'(1);
            end else begin
                xCnt <= effX + CNT_W'(1);
                yCnt <= effY;
            end
        end
    end

    // Shift the window left one column per beat; new right column is two lines up, one line up, current
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (iDVAL) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= tap2;
            win[1][2] <= tap1;
            win[2][2] <= iDATA;
        end
    end

    // Stage 0 flags: beat valid, and whether its window is incomplete or straddles a line wrap
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            v0 <= 1'b0;
            b0 <= 1'b0;
        end else begin
            v0 <= iDVAL;
            if (iDVAL) begin
                b0 <= (effX < TWO) || (effY < TWO);
            end
        end
    end

    // Both kernels straight off the window registers
    always_comb begin
        gx = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
           - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
        gy = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
           - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
    end

`ifdef SOBEL_MAG_EN
    logic signed [SW-1:0] sumX;
    logic signed [SW-1:0] sumY;

    // Stage 1: register both kernel sums for the magnitude estimate
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            sumX <= '0;
            sumY <= '0;
        end else if (v0) begin
            sumX <= gx;
            sumY <= gy;
        end
    end

    // Magnitude estimate |Gx|+|Gy| before saturation
    always_comb begin
        mag = {1'b0, absVal(sumX)} + {1'b0, absVal(sumY)};
    end
`else
    logic signed [SW-1:0] sumK;

    // Stage 1: register the kernel chosen at the last start of frame
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            sumK <= '0;
        end else if (v0) begin
            sumK <= (kerSel == KER_GY) ? gy : gx;
        end
    end

    // Magnitude of the selected kernel before saturation
    always_comb begin
        mag = {1'b0, absVal(sumK)};
    end
`endif

    // Saturate to the output pixel range: any bit above the pixel width means overflow
    always_comb begin
        satPix = (|mag[SW:DATA_W]) ? '1 : mag[DATA_W-1:0];
    end

    // Stage 1 flags follow the sums
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            v1 <= 1'b0;
            b1 <= 1'b0;
        end else begin
            v1 <= v0;
            if (v0) begin
                b1 <= b0;
            end
        end
    end

    // Stage 2: output register; data holds between valid beats, border beats emit zero
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oDATA <= '0;
            oDVAL <= 1'b0;
        end else begin
            oDVAL <= v1;
            if (v1) begin
                oDATA <= b1 ? '0 : satPix;
            end
        end
    end

endmodule

// File: doc/sobel_edge_filter.md
Name: sobel_edge_filter

Overview:
- Consumes the 12-bit greyscale pixel stream produced by the greyscale image-processing stage (raster order, one pixel per valid beat).
- Buffers two previous lines and forms a 3x3 window over the stream.
- Applies a Sobel kernel and emits one 12-bit edge-magnitude pixel per input beat, for the display path.

Parameters:
- DATA_W, 12, pixel width in and out.
- IMG_W, 1280, pixels per line; this is the line-buffer depth.
- CNT_W, 11, width of the internal column/row counters.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  reset. Asynchronous, active-high.
- iSOF  in  1  start of frame. Qualified by iDVAL; marks pixel (0,0).
- iDATA  in  DATA_W  greyscale pixel.
- iDVAL  in  1  input beat valid.
- iSel  in  1  kernel select: 0 = Gx (vertical edges), 1 = Gy (horizontal edges).
- oDATA  out  DATA_W  edge pixel.
- oDVAL  out  1  output beat valid.

Behaviour:
- Reset values:
  - oDATA=0, oDVAL=0.
  - Column counter x=0, row counter y=0.
  - Window registers = 0; pipeline valid bits = 0.
  - Latched select = 0.
  - Line-buffer contents are not cleared.
- Beat definition: a beat is an edge with iDVAL=1. With iDVAL=0, the window, counters and line buffers hold.
- Counters and frame sync:
  - x increments per beat and wraps IMG_W-1 -> 0; on wrap, y increments. y is not bounded; only iSOF resets it.
  - A beat with iSOF=1 is treated as (x,y)=(0,0). The counters load to x=1, y=0, and iSel is latched.
  - iSel is ignored at all other times.
- Line buffers:
  - Each beat writes iDATA at column x.
  - Taps return the same column from row y-1 (LB1) and row y-2 (LB2), i.e. read-before-write.
- Window: each beat shifts the 3x3 window left one column. The new right column is {LB2 tap, LB1 tap, iDATA} (top to bottom).
- Kernels, with p[r][c], r=0 top, c=0 left:
  - Gx = (p02+2p12+p22) - (p00+2p10+p20).
  - Gy = (p20+2p21+p22) - (p00+2p01+p02).
  - Signed arithmetic, DATA_W+4 bits wide; no overflow is possible.
- Output value: |G|, saturated to 2^DATA_W-1 (4095).
- Border rule: if the beat has x<2 or y<2 (window incomplete or wraps a line), the output pixel is 0.
  - The output for beat (x,y) is the window centred on (x-1,y-1).
  - Last column and last row centres are never emitted.
- Pipeline and latency:
  - Edge N: beat sampled, window shifted.
  - Edge N+1: kernel sums registered.
  - Edge N+2: abs/saturate registered into oDATA, with oDVAL=1.
  - Latency is exactly 2 edges. oDVAL is iDVAL delayed by 2 edges, so the output beat count equals the input beat count.
  - oDATA holds its last value while oDVAL=0.
- Back-to-back frames: iSOF arriving mid-line forces resync. In-flight pipeline beats still complete.
- Reset mid-frame:
  - All registers clear immediately and oDVAL drops.
  - Beats in flight are lost.
  - After release, counters start at (0,0), so the first two rows and columns output 0.

Optional Feature:
- SOBEL_MAG_EN defined: the output is sat(|Gx|+|Gy|) and iSel is ignored. Both kernels are computed in stage 1 and the sum is saturated in stage 2. Latency is unchanged.
- SOBEL_MAG_EN undefined: only the latched iSel kernel is output.

Decomposition:
- Package sobel_pkg holds:
  - DATA_W default.
  - Kernel select enum {KER_GX=0, KER_GY=1}.
  - SUM_W = DATA_W+4.
  - PIX_MAX = 2^DATA_W-1.
- One sub-module: sobel_line_buffer.
  - Single-port, depth IMG_W, DATA_W wide.
  - Read-before-write at one address per beat.
  - Instantiated twice and chained (LB1 output feeds LB2 write data).

Test Plan (IMG_W=8 unless noted):
- Flat frame, all pixels 100, iSel=0, 3 rows: all 24 outputs are 0; oDVAL count is 24; every oDVAL pulse is exactly 2 edges after its iDVAL beat.
- Vertical step, columns 0-3 = 0 and columns 4-7 = 1000, iSel=0, rows 0-2:
  - Row-2 outputs at x=4 and x=5 are 4000.
  - x=2, 3, 6, 7 give 0.
  - Rows 0-1 give 0.
  - Same image with iSel=1: all outputs are 0.
- Saturation: same step with 4095 instead of 1000: Gx = 16380, and x=4/5 output 4095. With SOBEL_MAG_EN, a diagonal step also saturates to 4095.
- Gapped input: iDVAL toggles 1,0,0,1 per pixel; outputs are identical to the gap-free run. oDVAL follows the same gap pattern shifted 2 edges. The window does not advance during gaps.
- iSel toggled 0->1 mid-frame: the output kernel stays Gx until the next iSOF, then becomes Gy.
- Reset and resync:
  - iRST pulsed at row 1, x=5: oDVAL is 0 from the reset edge.
  - A new frame with iSOF gives border zeros for rows 0-1, then correct values.
  - A spurious iSOF at row 2, x=3 restarts counting at (0,0), and the next outputs are 0.
